regfile_dump_reader: RTL and testbench

Read-side debug master for the CPU register file. On a start pulse it stalls architectural register writes and walks every register through a dedicated read port. It streams each (address, data) pair out on a valid/ready interface to the debug/display path, so the dump is a coherent snapshot. It then pulses done and releases the stall.

---
 rtl/regfile_dump_reader_if.sv | 27 ++
 rtl/regfile_dump_reader.sv | 68 ++++++
 tb/tb_regfile_dump_reader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_if.sv
// Debug-dump bus: register-file read port, CPU stall, and the (addr, data)
// valid/ready stream toward the display path.
interface regfile_dump_reader_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic                     start;
  logic [ADDRESS_WIDTH-1:0] rf_read_addr;
  logic [DATA_WIDTH-1:0]    rf_read_data;
  logic                     cpu_stall;
  logic                     dump_valid;
  logic                     dump_ready;
  logic [ADDRESS_WIDTH-1:0] dump_addr;
  logic [DATA_WIDTH-1:0]    dump_data;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, rf_read_data, dump_ready,
    output rf_read_addr, cpu_stall, dump_valid, dump_addr, dump_data, busy, done
  );

  modport slave (
    output start, rf_read_data, dump_ready,
    input  rf_read_addr, cpu_stall, dump_valid, dump_addr, dump_data, busy, done
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Stalls the CPU and streams a coherent snapshot of every register out as
// (addr, data) words, then pulses done and releases the stall.
module regfile_dump_reader #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_dump_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

  state_t                   r_state, w_next;
  logic [ADDRESS_WIDTH-1:0] r_cnt;
  logic                     r_valid;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     w_load;
  logic                     w_hs;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_hs   = r_valid && bus.dump_ready;
    case (r_state)
      IDLE:    if (bus.start) w_next = SCAN;
      SCAN: begin
        // refill the output register whenever it is empty or being drained
        w_load = !r_valid || bus.dump_ready;
        if (w_load && r_cnt == LAST_ADDR) w_next = DRAIN;
      end
      DRAIN:   if (w_hs) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) r_cnt <= '0;
      if (w_load) begin
        r_data  <= bus.rf_read_data;
        r_addr  <= r_cnt;
        r_valid <= 1'b1;
        r_cnt   <= r_cnt + 1'b1;
      end else if (r_state == DRAIN && w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.rf_read_addr = r_cnt;
  assign bus.busy         = (r_state == SCAN) || (r_state == DRAIN);
  assign bus.cpu_stall    = bus.busy;
  assign bus.done         = (r_state == DONE);
  assign bus.dump_valid   = r_valid;
  assign bus.dump_addr    = r_addr;
  assign bus.dump_data    = r_data;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench: a behavioural register file plus a snapshot model of the
// expected dump, checked scenario by scenario.
module tb_regfile_dump_reader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_dump_reader_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();

  regfile_dump_reader #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] regs [32];
  logic [31:0] exp_d [32];
  assign bus.rf_read_data = regs[bus.rf_read_addr];

  int checks = 0;
  int errors = 0;

  // stream monitor: records every accepted word with its cycle stamp
  logic [4:0]  acc_a [$];
  logic [31:0] acc_d [$];
  int          acc_c [$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, stall_cnt = 0, stab_err = 0;
  logic p_v = 1'b0, p_r = 1'b0, p_rst = 1'b1;
  logic [4:0]  p_a = '0;
  logic [31:0] p_d = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset && bus.dump_valid && bus.dump_ready) begin
      acc_a.push_back(bus.dump_addr);
      acc_d.push_back(bus.dump_data);
      acc_c.push_back(cyc);
    end
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus.cpu_stall) stall_cnt <= stall_cnt + 1;
    if (!p_rst && !reset && p_v && !p_r &&
        (!bus.dump_valid || bus.dump_addr != p_a || bus.dump_data != p_d))
      stab_err <= stab_err + 1;
    p_v   <= bus.dump_valid;
    p_r   <= bus.dump_ready;
    p_a   <= bus.dump_addr;
    p_d   <= bus.dump_data;
    p_rst <= reset;
  end

  task automatic pulse_start(input bit wr5, output int s);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk);
    // a CPU write on the start edge still lands and belongs to the snapshot
    if (wr5) regs[5] = 32'hDEADBEEF;
    #1 bus.start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_dump(input int pct, input int b_done);
    int n = 0;
    while (done_cnt == b_done && n < 1000) begin
      @(posedge clk); #1 bus.dump_ready = ($urandom_range(99) < pct);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL dump_timeout: no done after %0d cycles, required done", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.dump_valid, bus.busy, bus.cpu_stall, bus.done} !== 4'b0 ||
        bus.dump_addr !== 5'd0 || bus.dump_data !== 32'd0 || bus.rf_read_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: v=%b busy=%b stall=%b done=%b addr=%0d data=%h, required all 0",
               bus.dump_valid, bus.busy, bus.cpu_stall, bus.done, bus.dump_addr, bus.dump_data);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.dump_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b v=%b, required 0 0", bus.busy, bus.dump_valid);
    end
  endtask

  task automatic test_full_ready();
    int b = acc_a.size(), bd = done_cnt, bs = stall_cnt, s;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : 32'hA5A50000 + i;
    for (int i = 0; i < 32; i++) exp_d[i] = (i == 0) ? 32'd0 : 32'hA5A50000 + i;
    bus.dump_ready = 1'b1;
    pulse_start(1'b0, s);
    wait_dump(100, bd);
    checks++;
    if (acc_a.size() - b != 32) begin
      errors++;
      $display("FAIL full_count: got %0d words, required 32", acc_a.size() - b);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (b + i >= acc_a.size() || acc_a[b+i] !== i[4:0] || acc_d[b+i] !== exp_d[i]) begin
        errors++;
        $display("FAIL full_word%0d: got a=%0d d=%h, required a=%0d d=%h", i,
                 (b + i < acc_a.size()) ? acc_a[b+i] : 5'd0,
                 (b + i < acc_d.size()) ? acc_d[b+i] : 32'd0, i, exp_d[i]);
      end
    end
    if (acc_c.size() >= b + 32) begin
      checks++;
      if (acc_c[b] != s + 1 || acc_c[b+31] - acc_c[b] != 31) begin
        errors++;
        $display("FAIL full_timing: first=%0d span=%0d, required first=%0d span=31",
                 acc_c[b], acc_c[b+31] - acc_c[b], s + 1);
      end
      checks++;
      if (done_cyc != acc_c[b+31] + 1) begin
        errors++;
        $display("FAIL full_done_cycle: got %0d, required %0d", done_cyc, acc_c[b+31] + 1);
      end
    end
    checks++;
    if (stall_cnt - bs != 33 || done_cnt - bd != 1) begin
      errors++;
      $display("FAIL full_stall_done: stall=%0d done=%0d, required 33 1", stall_cnt - bs, done_cnt - bd);
    end
  endtask

  task automatic test_random_ready(input bit wr5, input string nm);
    int b = acc_a.size(), bd = done_cnt, bse = stab_err, s;
    regs[0] = 32'd0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    bus.dump_ready = $urandom_range(1);
    pulse_start(wr5, s);
    for (int i = 0; i < 32; i++) exp_d[i] = regs[i];
    if (wr5) begin
      checks++;
      if (exp_d[5] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL %s_model_r5: got %h, required deadbeef", nm, exp_d[5]);
      end
    end
    wait_dump(50, bd);
    checks++;
    if (acc_a.size() - b != 32 || done_cnt - bd != 1) begin
      errors++;
      $display("FAIL %s_count: words=%0d done=%0d, required 32 1", nm, acc_a.size() - b, done_cnt - bd);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (b + i >= acc_a.size() || acc_a[b+i] !== i[4:0] || acc_d[b+i] !== exp_d[i]) begin
        errors++;
        $display("FAIL %s_word%0d: got a=%0d d=%h, required a=%0d d=%h", nm, i,
                 (b + i < acc_a.size()) ? acc_a[b+i] : 5'd0,
                 (b + i < acc_d.size()) ? acc_d[b+i] : 32'd0, i, exp_d[i]);
      end
    end
    checks++;
    if (stab_err != bse) begin
      errors++;
      $display("FAIL %s_stability: %0d changes while stalled, required 0", nm, stab_err - bse);
    end
  endtask

  task automatic test_start_ignored();
    int b = acc_a.size(), bd = done_cnt, s, n = 0;
    bit sent = 1'b0;
    for (int i = 0; i < 32; i++) exp_d[i] = regs[i];
    bus.dump_ready = 1'b1;
    pulse_start(1'b0, s);
    while (done_cnt == bd && n < 200) begin
      @(posedge clk); #1;
      bus.start = (!sent && acc_a.size() - b == 10) || bus.done;
      if (acc_a.size() - b == 10) sent = 1'b1;
      n++;
    end
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (acc_a.size() - b != 32 || done_cnt - bd != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: words=%0d done=%0d busy=%b, required 32 1 0",
               acc_a.size() - b, done_cnt - bd, bus.busy);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (b + i >= acc_a.size() || acc_a[b+i] !== i[4:0] || acc_d[b+i] !== exp_d[i]) begin
        errors++;
        $display("FAIL ignore_word%0d: got a=%0d, required a=%0d", i,
                 (b + i < acc_a.size()) ? acc_a[b+i] : 5'd0, i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int b = acc_a.size(), bd = done_cnt, s, n = 0;
    bus.dump_ready = 1'b1;
    pulse_start(1'b0, s);
    while (acc_a.size() - b < 13 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.dump_valid, bus.busy, bus.cpu_stall, bus.done} !== 4'b0 ||
        bus.dump_addr !== 5'd0 || bus.dump_data !== 32'd0) begin
      errors++;
      $display("FAIL midreset_state: v=%b busy=%b stall=%b done=%b addr=%0d data=%h, required all 0",
               bus.dump_valid, bus.busy, bus.cpu_stall, bus.done, bus.dump_addr, bus.dump_data);
    end
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != bd) begin
      errors++;
      $display("FAIL midreset_no_done: done pulses=%0d, required 0", done_cnt - bd);
    end
    test_random_ready(1'b0, "after_reset");
  endtask

  task automatic test_drain_hold();
    int b = acc_a.size(), bd = done_cnt, s, n = 0;
    bus.dump_ready = 1'b1;
    pulse_start(1'b0, s);
    while (acc_a.size() - b < 31 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    bus.dump_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.dump_valid !== 1'b1 || bus.cpu_stall !== 1'b1 || bus.busy !== 1'b1 ||
          bus.done !== 1'b0 || bus.dump_addr !== 5'd31) begin
        errors++;
        $display("FAIL drain_hold%0d: v=%b stall=%b done=%b addr=%0d, required 1 1 0 31",
                 k, bus.dump_valid, bus.cpu_stall, bus.done, bus.dump_addr);
      end
    end
    bus.dump_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.dump_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_done: done=%b busy=%b stall=%b v=%b, required 1 0 0 0",
               bus.done, bus.busy, bus.cpu_stall, bus.dump_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || acc_a.size() - b != 32 || done_cnt - bd != 1) begin
      errors++;
      $display("FAIL drain_idle: done=%b busy=%b words=%0d pulses=%0d, required 0 0 32 1",
               bus.done, bus.busy, acc_a.size() - b, done_cnt - bd);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    test_reset();
    test_full_ready();
    test_random_ready(1'b0, "random_ready");
    test_random_ready(1'b1, "write_on_start");
    test_start_ignored();
    test_reset_mid();
    test_drain_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
